datapath: RTL and testbench
===========================

# datapath

A 32-bit bus-based CPU datapath: 16 general-purpose registers, PC, IR, MAR, MDR, HI, LO, a Y operand latch, a 64-bit Z result register and an ALU, all joined by one shared 32-bit bus. A control unit, or a testbench acting as one, drives every load, drive and ALU-select strobe directly; the block contains no sequencing logic. It sits between the future control FSM and the memory subsystem.

## Interface
Parameters: none. Data width is fixed at 32 bits.

Ports, in positional order, except that `clock` and `clear` are listed first here but are the last two positional ports:
- `clock` input 1: single clock, rising-edge.
- `clear` input 1: asynchronous, active-high reset.
- `R0in`..`R15in` input 1 each: load the bus into Rn.
- `R0out`..`R15out` input 1 each: drive Rn onto the bus.
- `PCin`, `PCout` input 1: load/drive PC.
- `IRin` input 1: load IR from the bus.
- `Yin` input 1: load Y from the bus.
- `Zin` input 1: load the 64-bit ALU result into Z.
- `MARin` input 1: load MAR from the bus.
- `MDRin` input 1: load MDR from `Mdatain`.
- `MDRout` input 1: drive MDR onto the bus.
- `HIin`, `HIout`, `LOin`, `LOout` input 1: load/drive HI and LO.
- `IncPC` input 1: force the ALU to compute bus+1.
- `Zhighout`, `Zlowout` input 1: drive Z[63:32] or Z[31:0] onto the bus.
- `ALUselect` input 4: ALU operation.
- `Mdatain` input 32: memory read data.

There are no output ports. Verification probes the internal registers hierarchically as `R0`..`R15`, `PC`, `IR`, `MAR`, `MDR`, `HI`, `LO`, `Y`, `Z` (64 bits) and `bus`.

## Operation
- **Bus:** a combinational mux driven by the *out strobes.
  - Priority when more than one strobe is high: R0 > … > R15 > HI > LO > Zhigh > Zlow > PC > MDR.
  - With no strobe high, the bus is 32'h0.
- **Registers:** every register loads its source on a rising edge while its *in strobe is high, and otherwise holds.
  - Sources are the bus, except MDR (from `Mdatain`) and Z (from the ALU).
  - R0 is an ordinary register.
- **ALU inputs:** A = Y, B = bus. Result is 64 bits; for 32-bit operations, Z[63:32] = 0.
- **IncPC:** when high, the result is B+1 regardless of `ALUselect`.
- **ALUselect encoding:**
  - 0000 ADD A+B
  - 0001 SUB A−B
  - 0010 SHR, logical, A>>B[4:0]
  - 0011 SHL A<<B[4:0]
  - 0100 ROR
  - 0101 ROL
  - 0110 AND
  - 0111 OR
  - 1000 MUL, signed, 64-bit product
  - 1001 DIV, signed: low = quotient, high = remainder
  - 1010 NEG −B
  - 1011 NOT ~B
  - Other codes: result 0.
- **Arithmetic rules:**
  - ADD, SUB and NEG wrap modulo 2^32.
  - Divide by zero gives quotient 0 and remainder A.
- **Reset:** `clear` high asynchronously zeroes all registers, including Z[63:0]. The zero holds while `clear` is high.

## Timing
- **Load latency:** one edge. A value placed on the bus in cycle n is visible in the destination after edge n.
- **Combinational path:** the bus and the ALU are purely combinational, so Y/B→Z completes in a single cycle.
- **Simultaneous load and drive:** the register captures the pre-edge bus value. For example, Zlowout+PCin loads PC from Z.
- **Multiple *in strobes:** all strobed destinations load the same bus value.
- **Held strobes:** strobes held across several edges reload every edge. This is legal; the block does not require strobes to be de-asserted.
- **Reset mid-operation:** reset takes effect immediately, without waiting for a clock edge. Loads resume on the first edge after `clear` falls.

## Structure
- **Shared package** `datapath_pkg`, holding:
  - the ALU opcode constants (ADD…NOT);
  - the width constant 32;
  - the bus-source select encoding.
- **Sub-modules:**
  - `reg32`: clock, `clear`, enable, d, q. Instantiated for the 16 GPRs plus the special registers, and reused twice for Z.
  - `alu`: combinational.

## Test plan
- **Register load:** `Mdatain`=0x12, MDRin; then MDRout+R2in → R2=0x12. Same sequence for R3=0x14 and R1=0x18.
- **Instruction fetch:**
  - From reset, PCout+MARin+IncPC+Zin → MAR=0 and Z=1.
  - Then Zlowout+PCin+MDRin with `Mdatain`=0x28918000 → PC=1 and MDR=0x28918000.
  - Then MDRout+IRin → IR=0x28918000.
- **AND:** R2out+Yin; then R3out, ALUselect=0110, Zin → Z=0x10; then Zlowout+R1in → R1=0x00000010.
- **MUL/DIV:**
  - Y=0xFFFFFFFE (−2), B=3, MUL → Z=0xFFFFFFFF_FFFFFFFA.
  - 20 DIV 6 → Zlow=3, Zhigh=2. Zhighout+HIin → HI=2.
- **Wrap and ADD:** Y=0xFFFFFFFF, B=1, ADD → Zlow=0, Zhigh=0.
- **Asynchronous clear:** with R1=0x18, pulse `clear` between edges → R1, PC, Z and all other registers are 0 immediately. The next strobed load succeeds.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared width, ALU opcodes and bus-source encoding for the datapath
package datapath_pkg;
  localparam int W = 32;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
    OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT
  } alu_op_e;
  typedef enum logic [2:0] {
    SRC_NONE, SRC_GPR, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR
  } bus_src_e;
endpackage

// File: rtl/datapath_units.sv
// datapath_units: the 32-bit load-enabled register and the combinational ALU
module reg32
  import datapath_pkg::*;
(
  input  logic         clock,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // load on enable, asynchronous clear wins
  always_ff @(posedge clock or posedge clear)
    if (clear) q <= '0;
    else if (enable) q <= d;
endmodule

module alu
  import datapath_pkg::*;
(
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic [3:0]     sel_i,
  input  logic           inc_i,
  output logic [2*W-1:0] res_o
);
  logic [4:0]   sh;
  logic [5:0]   rsh;
  logic         div0;
  logic         ovf;
  logic [W-1:0] dv;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic [2*W-1:0] prod;
  // result select; divisor is forced to 1 for divide-by-zero and INT_MIN/-1 so the divider never faults
  always_comb begin
    sh = b_i[4:0];
    rsh = 6'd32 - {1'b0, sh};
    div0 = b_i == '0;
    ovf = a_i == {1'b1, {(W-1){1'b0}}} && &b_i;
    dv = (div0 || ovf) ? {{(W-1){1'b0}}, 1'b1} : b_i;
    q = div0 ? '0 : W'($signed(a_i) / $signed(dv));
    r = div0 ? a_i : W'($signed(a_i) % $signed(dv));
    prod = {{W{a_i[W-1]}}, a_i} * {{W{b_i[W-1]}}, b_i};
    res_o = '0;
    if (inc_i) res_o = {{W{1'b0}}, b_i + 1'b1};
    else
      case (sel_i)
        OP_ADD: res_o = {{W{1'b0}}, a_i + b_i};
        OP_SUB: res_o = {{W{1'b0}}, a_i - b_i};
        OP_SHR: res_o = {{W{1'b0}}, a_i >> sh};
        OP_SHL: res_o = {{W{1'b0}}, a_i << sh};
        OP_ROR: res_o = {{W{1'b0}}, (a_i >> sh) | (a_i << rsh)};
        OP_ROL: res_o = {{W{1'b0}}, (a_i << sh) | (a_i >> rsh)};
        OP_AND: res_o = {{W{1'b0}}, a_i & b_i};
        OP_OR:  res_o = {{W{1'b0}}, a_i | b_i};
        OP_MUL: res_o = prod;
        OP_DIV: res_o = {r, q};
        OP_NEG: res_o = {{W{1'b0}}, -b_i};
        OP_NOT: res_o = {{W{1'b0}}, ~b_i};
        default: res_o = '0;
      endcase
  end
endmodule

// File: rtl/datapath.sv
// datapath: bus-based 32-bit CPU datapath with externally driven load/drive strobes
module datapath
  import datapath_pkg::*;
(
  input logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input logic PCin,
  input logic PCout,
  input logic IRin,
  input logic Yin,
  input logic Zin,
  input logic MARin,
  input logic MDRin,
  input logic MDRout,
  input logic HIin,
  input logic HIout,
  input logic LOin,
  input logic LOout,
  input logic IncPC,
  input logic Zhighout,
  input logic Zlowout,
  input logic [3:0] ALUselect,
  input logic [W-1:0] Mdatain,
  input logic clock,
  input logic clear
);
  logic [15:0] rin;
  logic [15:0] rout;
  logic [W-1:0] gpr [16];
  logic [W-1:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15;
  logic [W-1:0] PC, IR, MAR, MDR, HI, LO, Y, z_hi, z_lo, bus;
  logic [2*W-1:0] Z;
  logic [2*W-1:0] alu_res;
  bus_src_e src;
  logic [3:0] idx;
  assign rin = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                 R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  for (genvar i = 0; i < 16; i++) begin : g_gpr
    reg32 u_r (.clock(clock), .clear(clear), .enable(rin[i]), .d(bus), .q(gpr[i]));
  end
  assign {R0, R1, R2, R3, R4, R5, R6, R7} = {gpr[0], gpr[1], gpr[2], gpr[3], gpr[4], gpr[5], gpr[6], gpr[7]};
  assign {R8, R9, R10, R11, R12, R13, R14, R15} = {gpr[8], gpr[9], gpr[10], gpr[11], gpr[12], gpr[13], gpr[14], gpr[15]};
  reg32 u_pc  (.clock(clock), .clear(clear), .enable(PCin),  .d(bus),          .q(PC));
  reg32 u_ir  (.clock(clock), .clear(clear), .enable(IRin),  .d(bus),          .q(IR));
  reg32 u_mar (.clock(clock), .clear(clear), .enable(MARin), .d(bus),          .q(MAR));
  reg32 u_mdr (.clock(clock), .clear(clear), .enable(MDRin), .d(Mdatain),      .q(MDR));
  reg32 u_hi  (.clock(clock), .clear(clear), .enable(HIin),  .d(bus),          .q(HI));
  reg32 u_lo  (.clock(clock), .clear(clear), .enable(LOin),  .d(bus),          .q(LO));
  reg32 u_y   (.clock(clock), .clear(clear), .enable(Yin),   .d(bus),          .q(Y));
  reg32 u_zh  (.clock(clock), .clear(clear), .enable(Zin),   .d(alu_res[2*W-1:W]), .q(z_hi));
  reg32 u_zl  (.clock(clock), .clear(clear), .enable(Zin),   .d(alu_res[W-1:0]),   .q(z_lo));
  assign Z = {z_hi, z_lo};
  alu u_alu (.a_i(Y), .b_i(bus), .sel_i(ALUselect), .inc_i(IncPC), .res_o(alu_res));
  // bus source priority: lowest-priority strobes first so higher ones overwrite
  always_comb begin
    src = SRC_NONE;
    idx = '0;
    if (MDRout) src = SRC_MDR;
    if (PCout) src = SRC_PC;
    if (Zlowout) src = SRC_ZLO;
    if (Zhighout) src = SRC_ZHI;
    if (LOout) src = SRC_LO;
    if (HIout) src = SRC_HI;
    for (int k = 15; k >= 0; k--)
      if (rout[k]) begin
        src = SRC_GPR;
        idx = 4'(k);
      end
  end
  assign bus = src == SRC_GPR ? gpr[idx] :
               src == SRC_HI  ? HI :
               src == SRC_LO  ? LO :
               src == SRC_ZHI ? z_hi :
               src == SRC_ZLO ? z_lo :
               src == SRC_PC  ? PC :
               src == SRC_MDR ? MDR : '0;
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: random strobe stimulus checked every cycle against a behavioural model, plus literal test-plan checks
module tb_datapath;
  logic clk = 1'b0;
  logic clr;
  logic [15:0] rin, rout;
  logic pcin, pcout, irin, yin, zin, marin, mdrin, mdrout, hiin, hiout, loin, loout, incpc, zhout, zlout;
  logic [3:0] sel;
  logic [31:0] mdat;
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y;
  logic [63:0] m_z;
  logic [31:0] dr [16];
  int total = 0;
  int bad = 0;
  logic go = 1'b0;

  always #5 clk = ~clk;

  datapath dut (
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .PCin(pcin), .PCout(pcout), .IRin(irin), .Yin(yin), .Zin(zin), .MARin(marin),
    .MDRin(mdrin), .MDRout(mdrout), .HIin(hiin), .HIout(hiout), .LOin(loin), .LOout(loout),
    .IncPC(incpc), .Zhighout(zhout), .Zlowout(zlout), .ALUselect(sel), .Mdatain(mdat),
    .clock(clk), .clear(clr)
  );

  assign dr[0] = dut.R0;   assign dr[1] = dut.R1;   assign dr[2] = dut.R2;   assign dr[3] = dut.R3;
  assign dr[4] = dut.R4;   assign dr[5] = dut.R5;   assign dr[6] = dut.R6;   assign dr[7] = dut.R7;
  assign dr[8] = dut.R8;   assign dr[9] = dut.R9;   assign dr[10] = dut.R10; assign dr[11] = dut.R11;
  assign dr[12] = dut.R12; assign dr[13] = dut.R13; assign dr[14] = dut.R14; assign dr[15] = dut.R15;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] m_bus();
    for (int i = 0; i < 16; i++) if (rout[i]) return m_r[i];
    if (hiout) return m_hi;
    if (loout) return m_lo;
    if (zhout) return m_z[63:32];
    if (zlout) return m_z[31:0];
    if (pcout) return m_pc;
    if (mdrout) return m_mdr;
    return 32'h0;
  endfunction

  function automatic logic [63:0] alu_m(logic [31:0] a, logic [31:0] b, logic [3:0] s, logic inc);
    longint sa, sb;
    logic [31:0] lo;
    int n;
    sa = $signed(a);
    sb = $signed(b);
    n = int'(b[4:0]);
    if (inc) return {32'h0, b + 32'd1};
    case (s)
      4'd0: lo = a + b;
      4'd1: lo = a - b;
      4'd2: lo = a >> n;
      4'd3: lo = a << n;
      4'd4: lo = n == 0 ? a : (a >> n) | (a << (32 - n));
      4'd5: lo = n == 0 ? a : (a << n) | (a >> (32 - n));
      4'd6: lo = a & b;
      4'd7: lo = a | b;
      4'd8: return 64'(sa * sb);
      4'd9: return b == 32'h0 ? {a, 32'h0} : {32'(sa % sb), 32'(sa / sb)};
      4'd10: lo = -b;
      4'd11: lo = ~b;
      default: lo = 32'h0;
    endcase
    return {32'h0, lo};
  endfunction

  task automatic idle();
    rin = '0; rout = '0;
    {pcin, pcout, irin, yin, zin, marin, mdrin, mdrout, hiin, hiout, loin, loout, incpc, zhout, zlout} = '0;
    sel = 4'd0;
  endtask

  task automatic m_zero();
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    {m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y} = '0;
    m_z = 64'h0;
  endtask

  // one clock: model computes next state from pre-edge strobes, applied just after the edge
  task automatic tick();
    logic [31:0] b;
    logic [63:0] res;
    b = m_bus();
    res = alu_m(m_y, b, sel, incpc);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) if (rin[i]) m_r[i] = b;
    if (pcin) m_pc = b;
    if (irin) m_ir = b;
    if (marin) m_mar = b;
    if (hiin) m_hi = b;
    if (loin) m_lo = b;
    if (yin) m_y = b;
    if (mdrin) m_mdr = mdat;
    if (zin) m_z = res;
    idle();
  endtask

  task automatic pulse_clear();
    #1 clr = 1'b1;
    m_zero();
    #1 clr = 1'b0;
  endtask

  task automatic mdr_load(input logic [31:0] v);
    mdat = v; mdrin = 1'b1; tick();
  endtask

  task automatic load_y(input logic [31:0] v);
    mdr_load(v); mdrout = 1'b1; yin = 1'b1; tick();
  endtask

  task automatic alu_mdr(input logic [31:0] b, input logic [3:0] s);
    mdr_load(b); mdrout = 1'b1; sel = s; zin = 1'b1; tick();
  endtask

  // every-cycle comparison of all probed state and the bus against the model
  always @(negedge clk)
    if (go && !clr) begin
      for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), {32'h0, dr[i]}, {32'h0, m_r[i]});
      chk("PC", {32'h0, dut.PC}, {32'h0, m_pc});
      chk("IR", {32'h0, dut.IR}, {32'h0, m_ir});
      chk("MAR", {32'h0, dut.MAR}, {32'h0, m_mar});
      chk("MDR", {32'h0, dut.MDR}, {32'h0, m_mdr});
      chk("HI", {32'h0, dut.HI}, {32'h0, m_hi});
      chk("LO", {32'h0, dut.LO}, {32'h0, m_lo});
      chk("Y", {32'h0, dut.Y}, {32'h0, m_y});
      chk("Z", dut.Z, m_z);
      chk("bus", {32'h0, dut.bus}, {32'h0, m_bus()});
    end

  initial begin
    idle();
    mdat = 32'h0;
    clr = 1'b1;
    m_zero();
    #7;
    chk("reset_PC", {32'h0, dut.PC}, 64'h0);
    chk("reset_Z", dut.Z, 64'h0);
    #5 clr = 1'b0;
    go = 1'b1;
    mdr_load(32'h12); mdrout = 1'b1; rin[2] = 1'b1; tick();
    chk("lit_R2", {32'h0, dut.R2}, 64'h12);
    mdr_load(32'h14); mdrout = 1'b1; rin[3] = 1'b1; tick();
    mdr_load(32'h18); mdrout = 1'b1; rin[1] = 1'b1; tick();
    chk("lit_R3", {32'h0, dut.R3}, 64'h14);
    chk("lit_R1", {32'h0, dut.R1}, 64'h18);
    pcout = 1'b1; marin = 1'b1; incpc = 1'b1; zin = 1'b1; tick();
    chk("lit_fetch_MAR", {32'h0, dut.MAR}, 64'h0);
    chk("lit_fetch_Z", dut.Z, 64'h1);
    zlout = 1'b1; pcin = 1'b1; mdrin = 1'b1; mdat = 32'h28918000; tick();
    chk("lit_fetch_PC", {32'h0, dut.PC}, 64'h1);
    chk("lit_fetch_MDR", {32'h0, dut.MDR}, 64'h28918000);
    mdrout = 1'b1; irin = 1'b1; tick();
    chk("lit_IR", {32'h0, dut.IR}, 64'h28918000);
    rout[2] = 1'b1; yin = 1'b1; tick();
    rout[3] = 1'b1; sel = 4'b0110; zin = 1'b1; tick();
    chk("lit_and_Z", dut.Z, 64'h10);
    zlout = 1'b1; rin[1] = 1'b1; tick();
    chk("lit_and_R1", {32'h0, dut.R1}, 64'h10);
    load_y(32'hFFFFFFFE); alu_mdr(32'd3, 4'b1000);
    chk("lit_mul", dut.Z, 64'hFFFFFFFF_FFFFFFFA);
    load_y(32'd20); alu_mdr(32'd6, 4'b1001);
    chk("lit_div", dut.Z, 64'h00000002_00000003);
    zhout = 1'b1; hiin = 1'b1; tick();
    chk("lit_HI", {32'h0, dut.HI}, 64'h2);
    load_y(32'd7); alu_mdr(32'd0, 4'b1001);
    chk("lit_div0", dut.Z, 64'h00000007_00000000);
    load_y(32'h80000001); alu_mdr(32'd4, 4'b0100);
    chk("lit_ror", dut.Z, 64'h18000000);
    load_y(32'hFFFFFFFF); alu_mdr(32'd1, 4'b0000);
    chk("lit_add_wrap", dut.Z, 64'h0);
    load_y(32'h5); alu_mdr(32'd9, 4'b1010);
    chk("lit_neg", dut.Z, 64'hFFFFFFF7);
    mdr_load(32'h18); mdrout = 1'b1; rin[1] = 1'b1; tick();
    chk("lit_pre_clear_R1", {32'h0, dut.R1}, 64'h18);
    #1 clr = 1'b1;
    m_zero();
    #1;
    chk("lit_clear_R1", {32'h0, dut.R1}, 64'h0);
    chk("lit_clear_PC", {32'h0, dut.PC}, 64'h0);
    chk("lit_clear_Z", dut.Z, 64'h0);
    chk("lit_clear_MDR", {32'h0, dut.MDR}, 64'h0);
    clr = 1'b0;
    mdr_load(32'h55);
    chk("lit_after_clear", {32'h0, dut.MDR}, 64'h55);
    for (int c = 0; c < 600; c++) begin
      rin = 16'($urandom) & 16'($urandom);
      rout = 16'($urandom) & 16'($urandom) & 16'($urandom);
      {pcin, irin, yin, zin, marin, mdrin, hiin, loin} = 8'($urandom);
      pcout = $urandom_range(0, 5) == 0;
      mdrout = $urandom_range(0, 3) == 0;
      hiout = $urandom_range(0, 5) == 0;
      loout = $urandom_range(0, 5) == 0;
      zhout = $urandom_range(0, 5) == 0;
      zlout = $urandom_range(0, 5) == 0;
      incpc = $urandom_range(0, 7) == 0;
      sel = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: mdat = 32'h0;
        1: mdat = 32'h80000000;
        2: mdat = 32'hFFFFFFFF;
        3: mdat = 32'($urandom_range(0, 40));
        default: mdat = $urandom;
      endcase
      tick();
      if ($urandom_range(0, 59) == 0) pulse_clear();
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
